ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch stage that sits directly upstream of the decoder. It owns the fetch PC and issues in-order requests to the instruction memory over a valid/ready request channel. Responses are buffered in a 2-entry queue and presented to the decoder one instruction at a time, with the PC of each. Branch and jump redirects flush queued instructions and discard any responses still in flight.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- sys_clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- imem_req_valid  out  1  request is presented this cycle.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  32  word address of the request; always equals fetch_pc.
- imem_rsp_valid  in  1  response data valid; responses arrive in order, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- redirect  in  1  redirect fetch to redirect_pc (taken branch, jump, jr).
- redirect_pc  in  32  new fetch PC.
- is_stalling  in  1  downstream is holding; the head instruction is not consumed.
- ins_valid_o  out  1  the queue head is valid.
- ins_o  out  32  head instruction; 32'h0 (nop) when the queue is empty.
- pc_o  out  32  PC of the head instruction; 0 when the queue is empty.
- pc_plus4_o  out  32  pc_o + 4 (wraps mod 2^32); 0 when the queue is empty.

## Operation
- State:
  - fetch_pc (32 bits).
  - out_cnt: 0..2, accepted requests not yet answered.
  - tag queue: 2 entries, holding the PC of each outstanding request, in order.
  - inst queue: 2 entries of {pc, ins}, with count q_cnt 0..2.
  - drop_cnt: 0..2, in-flight responses still to be discarded.
- pop = ins_valid_o && !is_stalling.
- Request valid: imem_req_valid = !redirect && (out_cnt + q_cnt - pop < 2).
  - This credit rule guarantees every response fits in the queue, so is_stalling never blocks a response.
- Issue = imem_req_valid && imem_req_ready. On issue:
  - push fetch_pc into the tag queue;
  - fetch_pc <= fetch_pc + 4 (wraps mod 2^32);
  - out_cnt increments.
- Response (imem_rsp_valid with out_cnt > 0):
  - pop the tag queue and decrement out_cnt;
  - if drop_cnt > 0 or redirect is asserted, discard the data and decrement drop_cnt if it is nonzero;
  - otherwise push {tag, imem_rsp_data} into the inst queue.
  - imem_rsp_valid with out_cnt == 0 is a protocol violation: ignore it and leave all state unchanged.
- Redirect, with priority over everything else:
  - fetch_pc <= redirect_pc;
  - q_cnt <= 0, which also discards a pop in the same cycle;
  - drop_cnt <= out_cnt − (response this cycle ? 1 : 0);
  - no request is issued in the redirect cycle.
- Simultaneous push and pop: the count is unchanged and the queue head advances.
- ins_valid_o = (q_cnt != 0). The outputs come from the queue head, so they are register-driven.
- A reset asserted mid-operation clears all counters and queues immediately. Any responses to requests from before reset that arrive later are ignored as violations.
- Reset values: fetch_pc = RESET_PC; out_cnt = q_cnt = drop_cnt = 0; imem_req_valid = 0 while rst is high; ins_valid_o = 0; ins_o = pc_o = pc_plus4_o = 0.

## Timing
- imem_req_addr and imem_req_valid depend combinationally on is_stalling, redirect and the state. No other input-to-output combinational path exists.
- Latency:
  - A request accepted in cycle N gets its response at N+k, with k ≥ 1.
  - That instruction appears on ins_o at N+k+1.
  - A zero-latency response is not supported.
- Throughput: 1 instruction per cycle in steady state with k = 1, imem_req_ready held at 1 and no stall.
- First fetch after reset release:
  - cycle 0: request to RESET_PC;
  - cycle 1: response;
  - cycle 2: ins_valid_o = 1.
- Redirect in cycle R:
  - cycle R+1: first request to redirect_pc;
  - cycle R+3 at the earliest: the target instruction is valid, with k = 1 and all in-flight responses drained.
- Stall: ins_o, pc_o and pc_plus4_o hold stable while is_stalling = 1 and no redirect occurs.
- Backpressure: with imem_req_ready = 0, imem_req_valid and imem_req_addr hold stable until the request is accepted or a redirect occurs.

## Test plan
- Reset, 1-cycle memory returning addr|0xA000_0000, no stall:
  - requests at 0x0, 0x4, 0x8 on consecutive cycles;
  - ins_valid_o rises in cycle 2 with pc_o = 0x0, ins_o = 0xA000_0000, pc_plus4_o = 0x4.
- Hold is_stalling for 5 cycles after the first instruction:
  - the head holds at pc_o = 0x0;
  - out_cnt + q_cnt never exceeds 2 and no request issues once the queue is full;
  - after release, 0x4, 0x8 … follow with no gaps or duplicates.
- Memory latency 3 with 2 requests in flight; assert redirect to 0x100:
  - both stale responses are discarded and q_cnt = 0;
  - the next accepted request is to 0x100, and the first valid pc_o is 0x100.
- Redirect in the same cycle a response arrives:
  - that response is discarded and drop_cnt = out_cnt − 1;
  - no request issues in the redirect cycle.
- imem_req_ready held low for 4 cycles:
  - imem_req_addr stays at 0x8 throughout;
  - after acceptance, order is preserved.
- Assert rst mid-stream with 2 outstanding requests:
  - outputs go to 0 immediately;
  - after release, the first request is to RESET_PC and late stale responses never appear on ins_o.

Source files
------------

// File: rtl/ifetch.sv
// ifetch: fetch stage that owns the fetch PC and feeds the decoder from a 2-entry instruction queue.
// Latency: request accepted in cycle N, response at N+k (k >= 1), instruction on ins_o at N+k+1.
// Backpressure: requests are credit-limited (outstanding + queued <= 2), so is_stalling never blocks a
//               response; with imem_req_ready low the request and its address hold until accepted.
//
// Ports:
//   sys_clk, rst        clock; asynchronous active-high reset
//   imem_req_*          in-order request channel (valid/ready); imem_req_addr always equals fetch_pc
//   imem_rsp_*          in-order response channel; a response with nothing outstanding is ignored
//   redirect(_pc)       taken branch / jump target; flushes the queue and drops in-flight responses
//   is_stalling         decoder holds the head instruction
//   ins_valid_o, ins_o, pc_o, pc_plus4_o   queue head (zeros when the queue is empty)
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        sys_clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        is_stalling,
    output logic        ins_valid_o,
    output logic [31:0] ins_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
);

    logic [31:0] fetch_pc;
    logic [1:0]  out_cnt;
    logic [1:0]  q_cnt;
    logic [1:0]  drop_cnt;

    // Tag queue: PC of each outstanding request, in issue order.
    logic [31:0] tag_pc [2];
    logic        tag_rd_ptr;
    logic        tag_wr_ptr;

    // Instruction queue: {pc, ins} per entry.
    logic [31:0] q_pc  [2];
    logic [31:0] q_ins [2];
    logic        q_rd_ptr;
    logic        q_wr_ptr;

    logic        pop;
    logic        rsp;
    logic        issue;
    logic        keep_rsp;
    logic [2:0]  credit_used;

    assign ins_valid_o = (q_cnt != 2'd0);
    assign pop         = ins_valid_o && !is_stalling;

    // Every accepted request must have a queue slot waiting for it; a slot freed by
    // this cycle's pop can be handed out immediately.
    assign credit_used    = {1'b0, out_cnt} + {1'b0, q_cnt} - {2'b00, pop};
    assign imem_req_valid = !rst && !redirect && (credit_used < 3'd2);
    assign imem_req_addr  = fetch_pc;
    assign issue          = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rsp      = imem_rsp_valid && (out_cnt != 2'd0);
    assign keep_rsp = rsp && !redirect && (drop_cnt == 2'd0);

    assign ins_o      = ins_valid_o ? q_ins[q_rd_ptr] : 32'h0;
    assign pc_o       = ins_valid_o ? q_pc[q_rd_ptr]  : 32'h0;
    assign pc_plus4_o = ins_valid_o ? (q_pc[q_rd_ptr] + 32'd4) : 32'h0;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            out_cnt    <= 2'd0;
            q_cnt      <= 2'd0;
            drop_cnt   <= 2'd0;
            tag_rd_ptr <= 1'b0;
            tag_wr_ptr <= 1'b0;
            q_rd_ptr   <= 1'b0;
            q_wr_ptr   <= 1'b0;
        end else begin
            // The tag queue tracks the memory, not the decoder, so a redirect leaves it intact.
            if (rsp) begin
                tag_rd_ptr <= ~tag_rd_ptr;
            end
            if (issue) begin
                tag_wr_ptr <= ~tag_wr_ptr;
            end
            out_cnt <= out_cnt + {1'b0, issue} - {1'b0, rsp};

            if (redirect) begin
                fetch_pc <= redirect_pc;
                q_cnt    <= 2'd0;
                q_rd_ptr <= 1'b0;
                q_wr_ptr <= 1'b0;
                // Everything still outstanding after this cycle belongs to the old path.
                drop_cnt <= out_cnt - {1'b0, rsp};
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp && (drop_cnt != 2'd0)) begin
                    drop_cnt <= drop_cnt - 2'd1;
                end
                if (pop) begin
                    q_rd_ptr <= ~q_rd_ptr;
                end
                if (keep_rsp) begin
                    q_wr_ptr <= ~q_wr_ptr;
                end
                q_cnt <= q_cnt + {1'b0, keep_rsp} - {1'b0, pop};
            end
        end
    end

    // Payload storage needs no reset: entries are only read while the counts say they are valid.
    always_ff @(posedge sys_clk) begin
        if (issue) begin
            tag_pc[tag_wr_ptr] <= fetch_pc;
        end
        if (keep_rsp) begin
            q_pc[q_wr_ptr]  <= tag_pc[tag_rd_ptr];
            q_ins[q_wr_ptr] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        is_stalling;
    logic        ins_valid_o;
    logic [31:0] ins_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;

    ifetch dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .is_stalling   (is_stalling),
        .ins_valid_o   (ins_valid_o),
        .ins_o         (ins_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: fetch PC, outstanding request PCs, queued instruction PCs.
    logic [31:0] mfpc;
    int          mout;
    int          mdrop;
    logic [31:0] mq[$];
    logic [31:0] mtag[$];

    // Memory: in-order pending requests, each with the cycle its response is due.
    logic [31:0] mem_addr[$];
    int          mem_due[$];
    int          lat;
    int          cyc = 0;

    // Per-cycle snapshot for directed checks.
    logic        s_vld, s_rqv, s_acc;
    logic [31:0] s_ins, s_pc, s_p4, s_addr, s_acc_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a | 32'hA000_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mfpc  = 32'h0;
        mout  = 0;
        mdrop = 0;
        mq.delete();
        mtag.delete();
    endtask

    // One clock: present memory response, compare at negedge, advance model at posedge.
    task automatic cycle();
        logic        rv, pop, ev, rsp, iss;
        logic [31:0] rd, head, tag;
        int          occ;
        if (rst) model_reset();
        rv = (mem_addr.size() > 0) && (mem_due[0] <= cyc);
        rd = rv ? mem_word(mem_addr[0]) : 32'h0;
        imem_rsp_valid = rv;
        imem_rsp_data  = rd;
        @(negedge sys_clk);
        pop  = (mq.size() != 0) && !is_stalling;
        occ  = mout + mq.size() - (pop ? 1 : 0);
        ev   = !rst && !redirect && (occ < 2);
        head = (mq.size() != 0) ? mq[0] : 32'h0;
        s_vld = ins_valid_o; s_ins = ins_o; s_pc = pc_o; s_p4 = pc_plus4_o;
        s_rqv = imem_req_valid; s_addr = imem_req_addr;
        chk("req_valid", 32'(imem_req_valid), 32'(ev));
        chk("req_addr", imem_req_addr, mfpc);
        chk("ins_valid", 32'(ins_valid_o), 32'(mq.size() != 0));
        chk("ins", ins_o, (mq.size() != 0) ? mem_word(head) : 32'h0);
        chk("pc", pc_o, head);
        chk("pc_plus4", pc_plus4_o, (mq.size() != 0) ? head + 32'd4 : 32'h0);
        rsp = rv && (mout > 0);
        iss = ev && imem_req_ready;
        s_acc = iss;
        s_acc_addr = mfpc;
        @(posedge sys_clk);
        if (rv) begin
            void'(mem_addr.pop_front());
            void'(mem_due.pop_front());
        end
        if (iss) begin
            mem_addr.push_back(mfpc);
            mem_due.push_back(cyc + lat);
        end
        if (!rst) begin
            if (redirect) begin
                mfpc = redirect_pc;
                mq.delete();
                if (rsp) begin
                    void'(mtag.pop_front());
                    mout--;
                end
                mdrop = mout;
            end else begin
                if (pop) void'(mq.pop_front());
                if (rsp) begin
                    tag = mtag.pop_front();
                    mout--;
                    if (mdrop > 0) mdrop--;
                    else mq.push_back(tag);
                end
                if (iss) begin
                    mtag.push_back(mfpc);
                    mfpc = mfpc + 32'd4;
                    mout++;
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        redirect = 1'b0;
        repeat (n) cycle();
        rst = 1'b0;
    endtask

    initial begin
        logic        got_acc, got_vld;
        logic [31:0] first_acc, first_pc, first_p4, exp_pc;
        int          n;

        rst = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        redirect = 1'b0; redirect_pc = 32'h0; is_stalling = 1'b0; lat = 1;
        model_reset();

        // Reset state, then first fetches with 1-cycle memory.
        do_reset(2);
        chk("rst_ins_valid", 32'(s_vld), 32'h0);
        chk("rst_req_valid", 32'(s_rqv), 32'h0);
        chk("rst_req_addr", s_addr, 32'h0);
        cycle(); chk("c0_acc", s_acc ? s_acc_addr : 32'hDEAD_DEAD, 32'h0);
        cycle(); chk("c1_acc", s_acc ? s_acc_addr : 32'hDEAD_DEAD, 32'h4);
        cycle(); chk("c2_acc", s_acc ? s_acc_addr : 32'hDEAD_DEAD, 32'h8);
        chk("c2_vld", 32'(s_vld), 32'h1);
        chk("c2_pc", s_pc, 32'h0);
        chk("c2_ins", s_ins, 32'hA000_0000);
        chk("c2_p4", s_p4, 32'h4);
        repeat (5) cycle();

        // Stall the first instruction for 5 cycles.
        do_reset(1);
        cycle(); cycle();
        is_stalling = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_pc", s_pc, 32'h0);
            chk("stall_vld", 32'(s_vld), 32'h1);
        end
        is_stalling = 1'b0;
        exp_pc = 32'h0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (s_vld) begin
                chk("post_stall_seq", s_pc, exp_pc);
                exp_pc = exp_pc + 32'd4;
            end
        end

        // Latency 3, two in flight, redirect to 0x100.
        do_reset(1);
        lat = 3;
        n = 0;
        while (mout < 2 && n < 20) begin cycle(); n++; end
        chk("c_two_inflight", 32'(mout), 32'd2);
        redirect = 1'b1; redirect_pc = 32'h100;
        cycle();
        chk("c_redir_no_req", 32'(s_rqv), 32'h0);
        redirect = 1'b0;
        got_acc = 1'b0; got_vld = 1'b0; first_acc = 32'h0; first_pc = 32'h0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (s_acc && !got_acc) begin got_acc = 1'b1; first_acc = s_acc_addr; end
            if (s_vld && !got_vld) begin got_vld = 1'b1; first_pc = s_pc; end
        end
        chk("c_got_acc", 32'(got_acc), 32'h1);
        chk("c_first_acc", first_acc, 32'h100);
        chk("c_got_vld", 32'(got_vld), 32'h1);
        chk("c_first_pc", first_pc, 32'h100);

        // Redirect in the same cycle a response arrives; target wraps the address space.
        do_reset(1);
        lat = 2;
        n = 0;
        while (!(mout == 2 && mem_addr.size() > 0 && mem_due[0] <= cyc) && n < 20) begin
            cycle(); n++;
        end
        chk("d_rsp_with_redirect", 32'(n < 20), 32'h1);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cycle();
        chk("d_redir_no_req", 32'(s_rqv), 32'h0);
        chk("d_drop_cnt", 32'(mdrop), 32'd1);
        redirect = 1'b0;
        got_vld = 1'b0; first_pc = 32'h0; first_p4 = 32'hDEAD_DEAD;
        for (int i = 0; i < 15; i++) begin
            cycle();
            if (s_vld && !got_vld) begin got_vld = 1'b1; first_pc = s_pc; first_p4 = s_p4; end
        end
        chk("d_first_pc", first_pc, 32'hFFFF_FFFC);
        chk("d_wrap_p4", first_p4, 32'h0);

        // imem_req_ready low for 4 cycles while the request to 0x8 is pending.
        do_reset(1);
        lat = 1;
        cycle(); cycle();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("e_hold_vld", 32'(s_rqv), 32'h1);
            chk("e_hold_addr", s_addr, 32'h8);
        end
        imem_req_ready = 1'b1;
        cycle();
        chk("e_acc_addr", s_acc ? s_acc_addr : 32'hDEAD_DEAD, 32'h8);
        repeat (6) cycle();

        // Reset mid-stream with two requests outstanding.
        lat = 3;
        n = 0;
        while (mout < 2 && n < 20) begin cycle(); n++; end
        chk("f_two_inflight", 32'(mout), 32'd2);
        rst = 1'b1;
        cycle();
        chk("f_rst_vld", 32'(s_vld), 32'h0);
        chk("f_rst_ins", s_ins, 32'h0);
        chk("f_rst_pc", s_pc, 32'h0);
        chk("f_rst_p4", s_p4, 32'h0);
        chk("f_rst_req", 32'(s_rqv), 32'h0);
        rst = 1'b0;
        imem_req_ready = 1'b0;
        n = 0;
        while (mem_addr.size() > 0 && n < 10) begin cycle(); n++; end
        chk("f_stale_drained", 32'(mem_addr.size()), 32'd0);
        imem_req_ready = 1'b1; lat = 1;
        got_acc = 1'b0; got_vld = 1'b0; first_acc = 32'hDEAD_DEAD; first_pc = 32'hDEAD_DEAD;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (s_acc && !got_acc) begin got_acc = 1'b1; first_acc = s_acc_addr; end
            if (s_vld && !got_vld) begin got_vld = 1'b1; first_pc = s_pc; end
        end
        chk("f_first_acc", first_acc, 32'h0);
        chk("f_first_pc", first_pc, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            is_stalling    = ($urandom_range(0, 3) == 0);
            imem_req_ready = ($urandom_range(0, 4) != 0);
            lat            = $urandom_range(1, 3);
            redirect       = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom & 32'hFFFF_FFFC;
            cycle();
        end
        redirect = 1'b0;
        is_stalling = 1'b0;
        imem_req_ready = 1'b1;
        repeat (6) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
